// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the memory port arbiter.
//   arb_state_e : arbiter FSM states
//   mem_cmd_t   : one latched memory command (address, write enable,
//                 byte enables, write data)
//   REQ_*       : requester slot assignment on the req_i vector
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_e;

    // Command field widths; the top-level MEM_W must match CMD_DATA_W.
    localparam int unsigned CMD_ADDR_W = 32;
    localparam int unsigned CMD_DATA_W = 32;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0]   addr;
        logic                    we;
        logic [CMD_DATA_W/8-1:0] be;
        logic [CMD_DATA_W-1:0]   wdata;
    } mem_cmd_t;

    localparam int unsigned REQ_IFETCH = 0;
    localparam int unsigned REQ_DATA   = 1;
    localparam int unsigned REQ_VEC    = 2;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req     : request vector, one bit per requester
//   rr_ptr  : index that has priority this round
//   winner  : first requesting index at or above rr_ptr, wrapping
//   any_req : at least one request is pending (winner valid)
module rr_picker #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               any_req
);

    logic [PTR_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path leaves it unassigned (no latch).
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            idx = PTR_W'((int'(rr_ptr) + i) % int'(NUM_REQ));
            if (!any_req && req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the MMU memory request port among NUM_REQ
// requesters (instruction fetch, data, vector LSU) with round-robin
// arbitration, one outstanding transaction at a time.
//   clk, rst          : clock, synchronous active-low reset
//   req_i .. wdata_i  : packed per-requester commands
//   gnt_o             : one-cycle accept pulse to the winner
//   rvalid_o, err_o   : response to the winner only
//   rdata_o           : shared read data, zero unless rvalid_o is set
//   mem_*_o / mem_*_i : command to / response from the MMU
//   busy_o            : transaction in progress
//   timeout_o         : pulse when the MMU did not answer in time
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned MEM_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*32-1:0]  addr_i,
    input  logic [NUM_REQ-1:0]     we_i,
    input  logic [NUM_REQ*MEM_W/8-1:0] be_i,
    input  logic [NUM_REQ*MEM_W-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     rvalid_o,
    output logic [NUM_REQ-1:0]     err_o,
    output logic [MEM_W-1:0]       rdata_o,
    output logic                   mem_req_o,
    output logic [31:0]            mem_addr_o,
    output logic                   mem_we_o,
    output logic [MEM_W/8-1:0]     mem_be_o,
    output logic [MEM_W-1:0]       mem_wdata_o,
    input  logic                   mem_rvalid_i,
    input  logic                   mem_err_i,
    input  logic [MEM_W-1:0]       mem_rdata_i,
    output logic                   busy_o,
    output logic                   timeout_o
);

    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;

    arb_state_e          state, state_next;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    win;
    logic [TIMER_W-1:0]  timer;
    mem_cmd_t            cmd;

    logic [PTR_W-1:0]    pick;
    logic                any_req;
    logic                done;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req     (req_i),
        .rr_ptr  (rr_ptr),
        .winner  (pick),
        .any_req (any_req)
    );

    // The command bus always reflects the latched copy; it is cleared by
    // reset and only reloaded when a new winner is accepted.
    assign mem_addr_o  = cmd.addr;
    assign mem_we_o    = cmd.we;
    assign mem_be_o    = cmd.be;
    assign mem_wdata_o = cmd.wdata;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the latched command is data, but it drives the MMU bus
            // directly, so it is reset to give a defined all-zero port.
            state  <= IDLE;
            rr_ptr <= '0;
            win    <= '0;
            timer  <= '0;
            cmd    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win       <= pick;
                        cmd.addr  <= addr_i[32*pick +: 32];
                        cmd.we    <= we_i[pick];
                        cmd.be    <= be_i[(MEM_W/8)*pick +: MEM_W/8];
                        cmd.wdata <= wdata_i[MEM_W*pick +: MEM_W];
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    timer <= done ? '0 : timer + 1'b1;
                    if (done) begin
                        rr_ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        gnt_o      = '0;
        rvalid_o   = '0;
        err_o      = '0;
        rdata_o    = '0;
        mem_req_o  = 1'b0;
        timeout_o  = 1'b0;
        done       = 1'b0;
        busy_o     = (state != IDLE);
        case (state)
            IDLE: begin
                if (any_req) state_next = ISSUE;
            end
            ISSUE: begin
                gnt_o[win] = 1'b1;
                mem_req_o  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // Drop the request in the response cycle so the MMU does
                // not see it as a fresh command.
                mem_req_o = ~(mem_rvalid_i | mem_err_i);
                if (mem_err_i) begin
                    err_o[win] = 1'b1;
                    done       = 1'b1;
                end else if (mem_rvalid_i) begin
                    rvalid_o[win] = 1'b1;
                    rdata_o       = mem_rdata_i;
                    done          = 1'b1;
                end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    // Writes to unacknowledged peripherals complete as
                    // successful; a read with no data is an error.
                    timeout_o = 1'b1;
                    if (cmd.we) rvalid_o[win] = 1'b1;
                    else        err_o[win]    = 1'b1;
                    done = 1'b1;
                end
                if (done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized self-checking bench for mem_port_arbiter
// with a transaction-level reference model (pending-request set, priority
// pointer, expected completion kind).
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 3;
    localparam int MW = 32;
    localparam int TO = 8;

    localparam int KIND_RV     = 0;
    localparam int KIND_ERR    = 1;
    localparam int KIND_BOTH   = 2;
    localparam int KIND_SILENT = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_i, we_i;
    logic [N*32-1:0]   addr_i;
    logic [N*MW/8-1:0] be_i;
    logic [N*MW-1:0]   wdata_i;
    logic [N-1:0]      gnt_o, rvalid_o, err_o;
    logic [MW-1:0]     rdata_o;
    logic              mem_req_o, mem_we_o;
    logic [31:0]       mem_addr_o;
    logic [MW/8-1:0]   mem_be_o;
    logic [MW-1:0]     mem_wdata_o;
    logic              mem_rvalid_i, mem_err_i;
    logic [MW-1:0]     mem_rdata_i;
    logic              busy_o, timeout_o;

    mem_port_arbiter #(
        .NUM_REQ        (N),
        .MEM_W          (MW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_err_i    (mem_err_i),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: who is waiting, and who has priority next.
    int           model_ptr = 0;
    logic [N-1:0] pending   = '0;
    logic [31:0]  op_addr  [N];
    logic         op_we    [N];
    logic [3:0]   op_be    [N];
    logic [31:0]  op_wdata [N];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive();
        req_i = pending;
        for (int k = 0; k < N; k++) begin
            addr_i[32*k +: 32]  = op_addr[k];
            we_i[k]             = op_we[k];
            be_i[4*k +: 4]      = op_be[k];
            wdata_i[32*k +: 32] = op_wdata[k];
        end
    endtask

    task automatic rand_ops(input int k);
        op_addr[k]  = $urandom;
        op_we[k]    = 1'($urandom_range(0, 1));
        op_be[k]    = 4'($urandom_range(1, 15));
        op_wdata[k] = $urandom;
    endtask

    // Priority rule: first pending requester at or after the pointer.
    function automatic int model_pick(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            if (mask[(model_ptr + i) % N]) return (model_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst          = 1'b0;
        pending      = '0;
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        mem_rdata_i  = '0;
        drive();
        step();
        step();
        rst       = 1'b1;
        model_ptr = 0;
    endtask

    // One full transaction starting in an IDLE cycle; leaves the bench at
    // the start of the next IDLE cycle. kind/delay describe the MMU answer.
    task automatic run_txn(input int kind, input int delay, input logic [31:0] rdata,
                           input logic [N-1:0] late_mask, output int obs_w);
        int           w, last;
        logic [31:0]  e_addr, e_wdata;
        logic         e_we, e_to, resp_rv, resp_err;
        logic [3:0]   e_be;
        logic [N-1:0] e_rv, e_err, e_gnt;

        obs_w = -1;
        drive();
        #1;
        n_total++; if (gnt_o !== '0) $display("FAIL idle_gnt: got %b exp 000", gnt_o); else n_pass++;
        n_total++; if (mem_req_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL idle_req_busy: got req=%b busy=%b exp 0 0", mem_req_o, busy_o); else n_pass++;

        w = model_pick(pending);
        if (w < 0) begin
            n_total++;
            $display("FAIL txn_setup: no pending request");
            return;
        end
        e_addr = op_addr[w]; e_we = op_we[w]; e_be = op_be[w]; e_wdata = op_wdata[w];

        step();
        pending[w] = 1'b0;
        rand_ops(w);
        drive();
        #1;
        for (int k = 0; k < N; k++) if (gnt_o[k]) obs_w = k;
        e_gnt = '0; e_gnt[w] = 1'b1;
        n_total++; if (gnt_o !== e_gnt) $display("FAIL issue_gnt: got %b exp %b", gnt_o, e_gnt); else n_pass++;
        n_total++; if (mem_req_o !== 1'b1 || busy_o !== 1'b1)
            $display("FAIL issue_req_busy: got req=%b busy=%b exp 1 1", mem_req_o, busy_o); else n_pass++;
        n_total++; if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {e_addr, e_we, e_be, e_wdata})
            $display("FAIL issue_cmd: got %h/%b/%h/%h exp %h/%b/%h/%h", mem_addr_o, mem_we_o,
                     mem_be_o, mem_wdata_o, e_addr, e_we, e_be, e_wdata); else n_pass++;

        last = (kind == KIND_SILENT) ? TO : delay;
        for (int c = 1; c <= last; c++) begin
            step();
            resp_rv      = (c == last) && (kind == KIND_RV || kind == KIND_BOTH);
            resp_err     = (c == last) && (kind == KIND_ERR || kind == KIND_BOTH);
            mem_rvalid_i = resp_rv;
            mem_err_i    = resp_err;
            mem_rdata_i  = (c == last) ? rdata : $urandom;
            if (c == last) pending |= late_mask;
            drive();
            #1;
            e_to  = (kind == KIND_SILENT) && (c == TO);
            e_rv  = '0;
            e_err = '0;
            if (resp_err || (e_to && !e_we)) e_err[w] = 1'b1;
            else if (resp_rv || (e_to && e_we)) e_rv[w] = 1'b1;
            n_total++; if (mem_req_o !== !(resp_rv || resp_err))
                $display("FAIL wait_mem_req c=%0d: got %b exp %b", c, mem_req_o, !(resp_rv || resp_err)); else n_pass++;
            n_total++; if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {e_addr, e_we, e_be, e_wdata})
                $display("FAIL wait_cmd_hold c=%0d: got %h exp %h", c, mem_addr_o, e_addr); else n_pass++;
            n_total++; if (rvalid_o !== e_rv || err_o !== e_err)
                $display("FAIL wait_resp c=%0d: got rv=%b err=%b exp rv=%b err=%b", c, rvalid_o, err_o, e_rv, e_err); else n_pass++;
            n_total++; if (timeout_o !== e_to)
                $display("FAIL wait_timeout c=%0d: got %b exp %b", c, timeout_o, e_to); else n_pass++;
            n_total++; if (gnt_o !== '0 || busy_o !== 1'b1)
                $display("FAIL wait_gnt_busy c=%0d: got gnt=%b busy=%b exp 000 1", c, gnt_o, busy_o); else n_pass++;
            if (resp_rv && !resp_err) begin
                n_total++; if (rdata_o !== rdata)
                    $display("FAIL wait_rdata: got %h exp %h", rdata_o, rdata); else n_pass++;
            end else if (e_rv == '0) begin
                n_total++; if (rdata_o !== '0)
                    $display("FAIL wait_rdata_zero c=%0d: got %h exp 0", c, rdata_o); else n_pass++;
            end
        end

        step();
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        mem_rdata_i  = $urandom;
        drive();
        model_ptr = (w + 1) % N;
    endtask

    task automatic test_reset();
        int w;
        rst          = 1'b0;
        pending      = 3'b111;
        mem_rvalid_i = 1'b1;
        mem_err_i    = 1'b0;
        mem_rdata_i  = 32'hFFFF_FFFF;
        for (int k = 0; k < N; k++) rand_ops(k);
        drive();
        step();
        step();
        #1;
        n_total++; if ({gnt_o, rvalid_o, err_o, mem_req_o, busy_o, timeout_o} !== '0)
            $display("FAIL reset_ctrl: got gnt=%b rv=%b err=%b req=%b busy=%b to=%b exp all 0",
                     gnt_o, rvalid_o, err_o, mem_req_o, busy_o, timeout_o); else n_pass++;
        n_total++; if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, rdata_o} !== '0)
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h exp 0", mem_addr_o, mem_wdata_o, rdata_o); else n_pass++;
        do_reset();
        // First grant after reset must favour requester 0.
        pending = 3'b111;
        run_txn(KIND_RV, 2, $urandom, '0, w);
        n_total++; if (w != REQ_IFETCH) $display("FAIL reset_priority: got %0d exp 0", w); else n_pass++;
    endtask

    task automatic test_single_read();
        int w;
        do_reset();
        op_addr[REQ_DATA] = 32'h0000_1004;
        op_we[REQ_DATA]   = 1'b0;
        op_be[REQ_DATA]   = 4'hF;
        pending = 3'b010;
        run_txn(KIND_RV, 2, 32'hDEAD_BEEF, '0, w);
        n_total++; if (w != REQ_DATA) $display("FAIL single_read_winner: got %0d exp 1", w); else n_pass++;
    endtask

    task automatic test_round_robin();
        int w;
        int order [6] = '{0, 1, 2, 0, 1, 2};
        do_reset();
        for (int k = 0; k < N; k++) rand_ops(k);
        for (int i = 0; i < 6; i++) begin
            pending = 3'b111;
            run_txn(KIND_RV, $urandom_range(1, 4), $urandom, '0, w);
            n_total++; if (w != order[i]) $display("FAIL rr_order[%0d]: got %0d exp %0d", i, w, order[i]); else n_pass++;
        end
        pending = 3'b001;
        run_txn(KIND_RV, 1, $urandom, '0, w);
        n_total++; if (w != 0) $display("FAIL rr_single0: got %0d exp 0", w); else n_pass++;
        pending = 3'b001;
        run_txn(KIND_RV, 2, $urandom, '0, w);
        n_total++; if (w != 0) $display("FAIL rr_wrap: got %0d exp 0", w); else n_pass++;
    endtask

    task automatic test_error();
        int w;
        op_addr[REQ_VEC] = 32'h0000_0050;
        op_we[REQ_VEC]   = 1'b0;
        pending = 3'b100;
        run_txn(KIND_ERR, 2, $urandom, '0, w);
        n_total++; if (w != REQ_VEC) $display("FAIL err_winner: got %0d exp 2", w); else n_pass++;
        rand_ops(0);
        rand_ops(2);
        pending = 3'b101;
        run_txn(KIND_RV, 2, $urandom, '0, w);
        n_total++; if (w != REQ_IFETCH) $display("FAIL err_ptr_advance: got %0d exp 0", w); else n_pass++;
    endtask

    task automatic test_timeout();
        int w;
        op_addr[0] = 32'h0000_0101; op_we[0] = 1'b1; op_be[0] = 4'h1; op_wdata[0] = 32'h1;
        pending = 3'b001;
        run_txn(KIND_SILENT, 0, $urandom, '0, w);
        op_addr[1] = 32'h0000_0101; op_we[1] = 1'b0;
        pending = 3'b010;
        run_txn(KIND_SILENT, 0, $urandom, '0, w);
    endtask

    task automatic test_reset_mid_wait();
        int w;
        do_reset();
        rand_ops(0);
        pending = 3'b001;
        run_txn(KIND_RV, 1, $urandom, '0, w);
        rand_ops(1);
        pending = 3'b010;
        drive();
        step();
        pending = '0;
        drive();
        step();
        rst = 1'b0;
        #1;
        n_total++; if (busy_o !== 1'b1) $display("FAIL midreset_pre_busy: got %b exp 1", busy_o); else n_pass++;
        step();
        rst          = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_F00D;
        #1;
        n_total++; if ({gnt_o, rvalid_o, err_o, mem_req_o, busy_o, timeout_o} !== '0)
            $display("FAIL midreset_ctrl: got gnt=%b rv=%b err=%b req=%b busy=%b to=%b exp all 0",
                     gnt_o, rvalid_o, err_o, mem_req_o, busy_o, timeout_o); else n_pass++;
        n_total++; if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, rdata_o} !== '0)
            $display("FAIL midreset_data: got addr=%h rdata=%h exp 0", mem_addr_o, rdata_o); else n_pass++;
        step();
        #1;
        n_total++; if (rvalid_o !== '0 || rdata_o !== '0)
            $display("FAIL midreset_late_rvalid: got rv=%b rdata=%h exp 000 0", rvalid_o, rdata_o); else n_pass++;
        mem_rvalid_i = 1'b0;
        model_ptr    = 0;
        rand_ops(0);
        rand_ops(2);
        pending = 3'b101;
        run_txn(KIND_RV, 2, $urandom, '0, w);
        n_total++; if (w != 0) $display("FAIL midreset_ptr: got %0d exp 0", w); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int w;
        rand_ops(1);
        rand_ops(2);
        pending = 3'b010;
        run_txn(KIND_BOTH, 2, $urandom, 3'b100, w);
        n_total++; if (w != REQ_DATA) $display("FAIL b2b_first: got %0d exp 1", w); else n_pass++;
        run_txn(KIND_RV, 2, $urandom, '0, w);
        n_total++; if (w != REQ_VEC) $display("FAIL b2b_second: got %0d exp 2", w); else n_pass++;
    endtask

    task automatic test_random();
        int           w, kind;
        logic [N-1:0] add, late;
        for (int i = 0; i < 30; i++) begin
            add = N'($urandom_range(1, 7));
            for (int k = 0; k < N; k++) if (add[k] && !pending[k]) rand_ops(k);
            pending |= add;
            late = N'($urandom_range(0, 7)) & ~pending;
            for (int k = 0; k < N; k++) if (late[k]) rand_ops(k);
            kind = ($urandom_range(0, 9) == 0) ? KIND_SILENT : int'($urandom_range(0, 2));
            run_txn(kind, $urandom_range(1, 6), $urandom, late, w);
        end
        pending = '0;
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < N; k++) rand_ops(k);
        test_reset();
        test_single_read();
        test_round_robin();
        test_error();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
